parking_lot_top: RTL and testbench
==================================

Name: parking_lot_top

Overview:
Controller for a 7-floor automated parking tower, with two slots per floor and a single elevator whose entrance is floor 0. It accepts park (in) and retrieve (out) requests by 4-digit BCD licence plate and moves the car by elevator, at most one floor per cycle. It tracks SUV/sedan occupancy, avoids a leaking floor and computes a parking fee on retrieval. Exposes internal state for test.

Parameters:
SUV_FLOORS, 3, floors 1..SUV_FLOORS hold SUVs; the remaining floors up to 7 hold sedans (defaults: 6 SUV slots, 8 sedan slots).
FEE_SEDAN, 1, cents per parked cycle for a sedan.
FEE_SUV, 2, cents per parked cycle for an SUV.

Ports:
clock  in  1  single clock; all state updates on rising edge.
reset  in  1  synchronous, active-high.
license_plate  in  16  four BCD digits, [15:12] most significant.
in_mode  in  1  park request, level-sampled.
out_mode  in  1  retrieve request, level-sampled.
leakage  in  1  leakage present.
leakage_floor  in  3  leaking floor (1..7; 0 = no effect).
parked_1..parked_7  out  32 each  floor N slots: [31:16] = place 1 plate, [15:0] = place 0 plate; 0 = empty.
current_floor  out  3  elevator floor, 0..7.
moving  out  16  plate currently in elevator; 0 = empty.
plate_type  out  1  type of the plate being served: 1 = SUV, 0 = sedan.
fee  out  8  fee of the last retrieved car, in cents.
empty_suv, empty_sedan  out  4 each  free usable slots per type.
full_suv, full_sedan  out  1 each  high when the matching empty count is 0.
in_mode_internal, out_mode_internal, license_plate_internal  out  1/1/16  request buffer contents.
curr_state_for_test  out  3  FSM state encoding.
target_floor, target_place  out  3/1  slot chosen for the current job.

Behaviour:
- Reset: all parked_N, moving, fee, current_floor, target_*, buffer and per-slot counters = 0; FSM in IDLE; plate_type = 0.
- Plate type: odd least-significant digit (license_plate[0] = 1) -> SUV; otherwise sedan.
- Request buffer: one entry. On a rising edge with the buffer empty and in_mode or out_mode high, latch the mode bits and the plate. in_mode wins when both are high, so out_mode_internal = 0 in that case. Requests arriving while the buffer is full are dropped.
- FSM encoding: IDLE=000, LOAD=001, UP=010, STORE=011, DOWN=100, FETCH=101, UNLOAD=110.
- IDLE at floor 0 with the buffer full -> LOAD. The buffer is cleared on the same edge.
- LOAD (in):
  - Set plate_type.
  - Target = lowest non-leaking floor of that type with a free slot; place 0 is used before place 1.
  - If none is free, or the plate is already parked: reject (moving stays 0) and go to IDLE.
  - Otherwise moving <= plate and go to UP.
- LOAD (out):
  - Search all slots for the plate.
  - If not found -> IDLE; fee is unchanged.
  - If found -> target = that slot; go to UP with moving = 0.
- UP: if current_floor == target_floor, go to STORE (in) or FETCH (out); otherwise current_floor += 1.
- STORE: write the plate into the target slot, clear that slot's counter, moving <= 0, go to DOWN.
- FETCH:
  - Clear the slot; moving <= plate.
  - fee <= min(255, counter × FEE_SEDAN or FEE_SUV, by the plate's type).
  - Go to DOWN.
- DOWN: current_floor -= 1 each cycle. At floor 0, go to UNLOAD if moving != 0, else to IDLE.
- UNLOAD: moving <= 0, go to IDLE.
- Timing: current_floor never changes by more than 1 per cycle.
- Slot counters: 8-bit, saturating; each increments every cycle its slot is occupied.
- Leakage:
  - While leakage = 1 and leakage_floor is 1..7, that floor is excluded from target selection and from the empty counts.
  - Cars already on it stay there and remain retrievable.
  - A leaking floor at the moment of STORE does not abort the STORE.
- empty_* and full_* are combinational from the current occupancy and leakage.
- Reset has priority at any point, including mid-job: the car in the elevator is discarded.

Optional Feature:
PLATE_CHECK_EN
- Defined: a request whose plate is 0, or has any digit > 9, is not latched into the buffer.
- Undefined: every plate is accepted as given.

Test Plan:
1. Reset, then in_mode for 1 cycle with plate 9423:
   - SUV; target_floor 1, place 0.
   - moving = 9423 during UP; parked_1[15:0] = 0x9423.
   - Elevator returns to 0; empty_suv goes 6 -> 5.
2. Right after scenario 1, in_mode with plate 8754 held for 4 cycles:
   - Buffered while busy; sedan.
   - Ends in parked_4[15:0] = 0x8754, floors visited in unit steps 0->4->0.
   - Accepted exactly once; no duplicate parking.
3. out_mode with plate 8754:
   - Elevator goes to floor 4, FETCH, returns with moving = 8754.
   - moving drops to 0 at UNLOAD; fee = parked cycles × 1; parked_4 cleared.
4. Fill all 6 SUV slots:
   - full_suv = 1.
   - A further SUV in-request is rejected; parked_* unchanged; back to IDLE.
5. leakage = 1, leakage_floor = 1, then park an SUV:
   - Goes to floor 2.
   - empty_suv excludes floor 1's free slots while leakage is asserted.
6. Assert reset during UP:
   - Next cycle all outputs are 0, state 000, current_floor 0.

Source files
------------

// File: rtl/parking_lot_top.sv
// parking_lot_top: controller for a 7-floor parking tower. Each floor has two
// slots. A single elevator enters at floor 0 and moves one floor per cycle.
// Floors 1..SUV_FLOORS hold SUVs and the floors above them hold sedans.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   license_plate[15:0]          4 BCD digits; an odd LSB marks an SUV
//   in_mode / out_mode           park / retrieve request (in_mode wins)
//   leakage, leakage_floor[2:0]  while asserted, that floor takes no new cars
//   parked_1..parked_7[31:0]     {place 1 plate, place 0 plate}, 0 = empty
//   current_floor, moving        elevator position and the plate it carries
//   plate_type, fee              type of the plate being served, last fee
//   empty_*/full_*               usable free slots per type
//   *_internal                   one-entry request buffer
//   curr_state_for_test          FSM encoding
//   target_floor, target_place   slot chosen for the current job
//
// Optional build macro PLATE_CHECK_EN: when defined, the buffer does not
// latch a plate that is zero or that has any digit above 9.
//
// state  | meaning
// IDLE   | at floor 0, waiting for a buffered request
// LOAD   | pick the target slot, or reject the request
// UP     | climb one floor per cycle to the target floor
// STORE  | write the plate into the target slot
// DOWN   | descend one floor per cycle to floor 0
// FETCH  | take the car from its slot and compute the fee
// UNLOAD | hand the retrieved car out at floor 0
module parking_lot_top #(
  parameter int SUV_FLOORS = 3,
  parameter int FEE_SEDAN  = 1,
  parameter int FEE_SUV    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] license_plate,
  input  logic        in_mode,
  input  logic        out_mode,
  input  logic        leakage,
  input  logic [2:0]  leakage_floor,
  output logic [31:0] parked_1,
  output logic [31:0] parked_2,
  output logic [31:0] parked_3,
  output logic [31:0] parked_4,
  output logic [31:0] parked_5,
  output logic [31:0] parked_6,
  output logic [31:0] parked_7,
  output logic [2:0]  current_floor,
  output logic [15:0] moving,
  output logic        plate_type,
  output logic [7:0]  fee,
  output logic [3:0]  empty_suv,
  output logic [3:0]  empty_sedan,
  output logic        full_suv,
  output logic        full_sedan,
  output logic        in_mode_internal,
  output logic        out_mode_internal,
  output logic [15:0] license_plate_internal,
  output logic [2:0]  curr_state_for_test,
  output logic [2:0]  target_floor,
  output logic        target_place
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_LOAD   = 3'b001,
    S_UP     = 3'b010,
    S_STORE  = 3'b011,
    S_DOWN   = 3'b100,
    S_FETCH  = 3'b101,
    S_UNLOAD = 3'b110
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_slot [1:7][0:1];
  logic [7:0]  r_cnt  [1:7][0:1];
  logic        r_buf_in, r_buf_out;
  logic [15:0] r_buf_plate;
  logic        r_job_in;
  logic [15:0] r_job_plate;
  logic [2:0]  r_floor, r_tgt_floor;
  logic        r_tgt_place, r_type;
  logic [15:0] r_moving;
  logic [7:0]  r_fee;

  logic        w_buf_full, w_leak_act, w_plate_ok, w_accept_in, w_take;
  logic        w_free_found, w_free_place, w_hit_found, w_hit_place;
  logic [2:0]  w_free_floor, w_hit_floor;
  logic [3:0]  w_empty_suv, w_empty_sedan;
  logic [15:0] w_rate, w_fee_full;

  assign w_buf_full = r_buf_in | r_buf_out;
  assign w_leak_act = leakage && (leakage_floor != 3'd0);
  assign w_take     = (r_state == S_IDLE) && w_buf_full && (r_floor == 3'd0);

`ifdef PLATE_CHECK_EN
  assign w_plate_ok = (license_plate != 16'd0) &&
                      (license_plate[15:12] <= 4'd9) && (license_plate[11:8] <= 4'd9) &&
                      (license_plate[7:4] <= 4'd9) && (license_plate[3:0] <= 4'd9);
`else
  assign w_plate_ok = 1'b1;
`endif

  // Walk the slots from the top down so that the lowest floor and place 0
  // end up holding the result.
  always_comb begin
    w_free_found  = 1'b0;
    w_free_floor  = 3'd0;
    w_free_place  = 1'b0;
    w_hit_found   = 1'b0;
    w_hit_floor   = 3'd0;
    w_hit_place   = 1'b0;
    w_empty_suv   = 4'd0;
    w_empty_sedan = 4'd0;
    for (int f = 7; f >= 1; f--) begin
      for (int p = 1; p >= 0; p--) begin
        if (r_slot[f][p] == 16'd0 && !(w_leak_act && leakage_floor == 3'(f))) begin
          if (f <= SUV_FLOORS) w_empty_suv = w_empty_suv + 4'd1;
          else                 w_empty_sedan = w_empty_sedan + 4'd1;
          if ((f <= SUV_FLOORS) == r_job_plate[0]) begin
            w_free_found = 1'b1;
            w_free_floor = 3'(f);
            w_free_place = (p != 0);
          end
        end
        if (r_slot[f][p] != 16'd0 && r_slot[f][p] == r_job_plate) begin
          w_hit_found = 1'b1;
          w_hit_floor = 3'(f);
          w_hit_place = (p != 0);
        end
      end
    end
  end

  assign w_accept_in = w_free_found && !w_hit_found && (r_job_plate != 16'd0);
  assign w_rate      = r_job_plate[0] ? 16'(FEE_SUV) : 16'(FEE_SEDAN);
  assign w_fee_full  = 16'(r_cnt[r_tgt_floor][r_tgt_place]) * w_rate;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_take) w_next = S_LOAD;
      S_LOAD:   if (r_job_in) w_next = w_accept_in ? S_UP : S_IDLE;
                else          w_next = w_hit_found ? S_UP : S_IDLE;
      S_UP:     if (r_floor == r_tgt_floor) w_next = r_job_in ? S_STORE : S_FETCH;
      S_STORE:  w_next = S_DOWN;
      S_FETCH:  w_next = S_DOWN;
      S_DOWN:   if (r_floor == 3'd0) w_next = (r_moving != 16'd0) ? S_UNLOAD : S_IDLE;
      S_UNLOAD: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_buf_in    <= 1'b0;
      r_buf_out   <= 1'b0;
      r_buf_plate <= 16'd0;
      r_job_in    <= 1'b0;
      r_job_plate <= 16'd0;
      r_floor     <= 3'd0;
      r_tgt_floor <= 3'd0;
      r_tgt_place <= 1'b0;
      r_type      <= 1'b0;
      r_moving    <= 16'd0;
      r_fee       <= 8'd0;
      for (int f = 1; f <= 7; f++) begin
        for (int p = 0; p < 2; p++) begin
          r_slot[f][p] <= 16'd0;
          r_cnt[f][p]  <= 8'd0;
        end
      end
    end else begin
      if (w_take) begin
        r_job_in    <= r_buf_in;
        r_job_plate <= r_buf_plate;
        r_buf_in    <= 1'b0;
        r_buf_out   <= 1'b0;
        r_buf_plate <= 16'd0;
      end else if (!w_buf_full && (in_mode || out_mode) && w_plate_ok) begin
        r_buf_in    <= in_mode;
        r_buf_out   <= !in_mode;
        r_buf_plate <= license_plate;
      end

      for (int f = 1; f <= 7; f++) begin
        for (int p = 0; p < 2; p++) begin
          if (r_slot[f][p] != 16'd0 && r_cnt[f][p] != 8'hFF) r_cnt[f][p] <= r_cnt[f][p] + 8'd1;
        end
      end

      case (r_state)
        S_LOAD: begin
          r_type <= r_job_plate[0];
          if (r_job_in) begin
            if (w_accept_in) begin
              r_moving    <= r_job_plate;
              r_tgt_floor <= w_free_floor;
              r_tgt_place <= w_free_place;
            end
          end else if (w_hit_found) begin
            r_tgt_floor <= w_hit_floor;
            r_tgt_place <= w_hit_place;
          end
        end
        S_UP: if (r_floor != r_tgt_floor) r_floor <= r_floor + 3'd1;
        S_STORE: begin
          r_slot[r_tgt_floor][r_tgt_place] <= r_job_plate;
          r_cnt[r_tgt_floor][r_tgt_place]  <= 8'd0;
          r_moving <= 16'd0;
        end
        S_FETCH: begin
          r_slot[r_tgt_floor][r_tgt_place] <= 16'd0;
          r_cnt[r_tgt_floor][r_tgt_place]  <= 8'd0;
          r_moving <= r_job_plate;
          r_fee    <= (w_fee_full > 16'd255) ? 8'hFF : w_fee_full[7:0];
        end
        S_DOWN:   if (r_floor != 3'd0) r_floor <= r_floor - 3'd1;
        S_UNLOAD: r_moving <= 16'd0;
        default: ;
      endcase
    end
  end

  assign parked_1 = {r_slot[1][1], r_slot[1][0]};
  assign parked_2 = {r_slot[2][1], r_slot[2][0]};
  assign parked_3 = {r_slot[3][1], r_slot[3][0]};
  assign parked_4 = {r_slot[4][1], r_slot[4][0]};
  assign parked_5 = {r_slot[5][1], r_slot[5][0]};
  assign parked_6 = {r_slot[6][1], r_slot[6][0]};
  assign parked_7 = {r_slot[7][1], r_slot[7][0]};
  assign current_floor          = r_floor;
  assign moving                 = r_moving;
  assign plate_type             = r_type;
  assign fee                    = r_fee;
  assign empty_suv              = w_empty_suv;
  assign empty_sedan            = w_empty_sedan;
  assign full_suv               = (w_empty_suv == 4'd0);
  assign full_sedan             = (w_empty_sedan == 4'd0);
  assign in_mode_internal       = r_buf_in;
  assign out_mode_internal      = r_buf_out;
  assign license_plate_internal = r_buf_plate;
  assign curr_state_for_test    = r_state;
  assign target_floor           = r_tgt_floor;
  assign target_place           = r_tgt_place;

endmodule

// File: tb/tb_parking_lot_top.sv
// Directed bench for parking_lot_top. Park jobs push their expected slot into
// a scoreboard queue, and the queue is popped when the DUT reaches STORE.
// Fees are predicted from the occupancy that the bench observes on the slot.
module tb_parking_lot_top;
  logic        clock = 1'b0;
  logic        reset, in_mode, out_mode, leakage;
  logic [15:0] license_plate;
  logic [2:0]  leakage_floor;
  logic [31:0] parked_1, parked_2, parked_3, parked_4, parked_5, parked_6, parked_7;
  logic [2:0]  current_floor, curr_state_for_test, target_floor;
  logic [15:0] moving, license_plate_internal;
  logic        plate_type, full_suv, full_sedan, in_mode_internal, out_mode_internal, target_place;
  logic [7:0]  fee;
  logic [3:0]  empty_suv, empty_sedan;

  parking_lot_top dut (
    .clock(clock), .reset(reset), .license_plate(license_plate),
    .in_mode(in_mode), .out_mode(out_mode), .leakage(leakage), .leakage_floor(leakage_floor),
    .parked_1(parked_1), .parked_2(parked_2), .parked_3(parked_3), .parked_4(parked_4),
    .parked_5(parked_5), .parked_6(parked_6), .parked_7(parked_7),
    .current_floor(current_floor), .moving(moving), .plate_type(plate_type), .fee(fee),
    .empty_suv(empty_suv), .empty_sedan(empty_sedan), .full_suv(full_suv), .full_sedan(full_sedan),
    .in_mode_internal(in_mode_internal), .out_mode_internal(out_mode_internal),
    .license_plate_internal(license_plate_internal), .curr_state_for_test(curr_state_for_test),
    .target_floor(target_floor), .target_place(target_place)
  );

  always #5 clock = ~clock;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_UP = 3'd2, ST_STORE = 3'd3,
                         ST_DOWN = 3'd4, ST_FETCH = 3'd5, ST_UNLOAD = 3'd6;

  typedef struct {
    logic [2:0]  fl;
    logic        pl;
    logic [15:0] plate;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int occ4 = 0, occ1 = 0, step_err = 0, max_floor = 0, prev_floor = 0;

  always @(negedge clock) begin
    if (parked_4[15:0] == 16'h8754) occ4++;
    if (parked_1[15:0] == 16'h9423) occ1++;
    if (reset === 1'b0) begin
      if (int'(current_floor) > prev_floor + 1 || prev_floor > int'(current_floor) + 1) step_err++;
      if (int'(current_floor) > max_floor) max_floor = int'(current_floor);
    end
    prev_floor = int'(current_floor);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wait_state(input logic [2:0] st, input string tag);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (curr_state_for_test === st) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) chk({tag, "_timeout"}, {29'd0, curr_state_for_test}, {29'd0, st});
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (curr_state_for_test === ST_IDLE && current_floor === 3'd0 &&
          in_mode_internal === 1'b0 && out_mode_internal === 1'b0) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) chk({tag, "_idle_timeout"}, {29'd0, curr_state_for_test}, 32'd0);
  endtask

  task automatic request(input logic dir_in, input logic [15:0] plate, input int hold);
    license_plate = plate;
    in_mode  = dir_in;
    out_mode = !dir_in;
    for (int i = 0; i < hold; i++) step();
    in_mode  = 1'b0;
    out_mode = 1'b0;
  endtask

  task automatic run_park(input string tag);
    exp_t e;
    wait_state(ST_UP, tag);
    chk({tag, "_moving_up"}, {16'd0, moving}, {16'd0, sb[0].plate});
    wait_state(ST_STORE, tag);
    e = sb.pop_front();
    chk({tag, "_tfloor"}, {29'd0, target_floor}, {29'd0, e.fl});
    chk({tag, "_tplace"}, {31'd0, target_place}, {31'd0, e.pl});
    chk({tag, "_type"}, {31'd0, plate_type}, {31'd0, e.plate[0]});
    wait_idle(tag);
  endtask

  task automatic run_fetch(input string tag, input logic [2:0] fl, input logic [15:0] plate);
    request(1'b0, plate, 1);
    wait_state(ST_FETCH, tag);
    chk({tag, "_tfloor"}, {29'd0, target_floor}, {29'd0, fl});
    chk({tag, "_moving_fetch"}, {16'd0, moving}, 32'd0);
    step();
    chk({tag, "_moving_down"}, {16'd0, moving}, {16'd0, plate});
    wait_state(ST_UNLOAD, tag);
    step();
    chk({tag, "_moving_unload"}, {16'd0, moving}, 32'd0);
    wait_idle(tag);
  endtask

  initial begin
    int exp_fee;
    reset = 1'b1; in_mode = 1'b0; out_mode = 1'b0; leakage = 1'b0;
    leakage_floor = 3'd0; license_plate = 16'd0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_state", {29'd0, curr_state_for_test}, 32'd0);
    chk("rst_floor", {29'd0, current_floor}, 32'd0);
    chk("rst_moving", {16'd0, moving}, 32'd0);
    chk("rst_fee", {24'd0, fee}, 32'd0);
    chk("rst_empty_suv", {28'd0, empty_suv}, 32'd6);
    chk("rst_empty_sedan", {28'd0, empty_sedan}, 32'd8);
    chk("rst_full", {30'd0, full_suv, full_sedan}, 32'd0);

    // scenario 1: first SUV goes to floor 1 place 0
    sb.push_back('{3'd1, 1'b0, 16'h9423});
    request(1'b1, 16'h9423, 1);
    run_park("s1");
    chk("s1_parked1", parked_1, 32'h0000_9423);
    chk("s1_empty_suv", {28'd0, empty_suv}, 32'd5);

    // scenario 2: sedan request held for 4 cycles is parked exactly once
    max_floor = 0;
    sb.push_back('{3'd4, 1'b0, 16'h8754});
    request(1'b1, 16'h8754, 4);
    run_park("s2");
    chk("s2_parked4", parked_4, 32'h0000_8754);
    chk("s2_empty_sedan", {28'd0, empty_sedan}, 32'd7);
    chk("s2_max_floor", max_floor, 32'd4);

    // scenario 3: retrieve the sedan; fee is one cent per counted cycle
    run_fetch("s3", 3'd4, 16'h8754);
    exp_fee = (occ4 - 1 > 255) ? 255 : occ4 - 1;
    chk("s3_fee", {24'd0, fee}, exp_fee);
    chk("s3_parked4", parked_4, 32'd0);

    // scenario 4: fill every SUV slot, then one more SUV is rejected
    sb.push_back('{3'd1, 1'b1, 16'h1111}); request(1'b1, 16'h1111, 1); run_park("s4a");
    sb.push_back('{3'd2, 1'b0, 16'h2223}); request(1'b1, 16'h2223, 1); run_park("s4b");
    sb.push_back('{3'd2, 1'b1, 16'h3335}); request(1'b1, 16'h3335, 1); run_park("s4c");
    sb.push_back('{3'd3, 1'b0, 16'h4447}); request(1'b1, 16'h4447, 1); run_park("s4d");
    sb.push_back('{3'd3, 1'b1, 16'h5559}); request(1'b1, 16'h5559, 1); run_park("s4e");
    chk("s4_full_suv", {31'd0, full_suv}, 32'd1);
    chk("s4_empty_suv", {28'd0, empty_suv}, 32'd0);
    request(1'b1, 16'h6661, 1);
    wait_state(ST_LOAD, "s4_rej");
    step();
    chk("s4_rej_state", {29'd0, curr_state_for_test}, 32'd0);
    chk("s4_rej_moving", {16'd0, moving}, 32'd0);
    chk("s4_parked1", parked_1, 32'h1111_9423);
    chk("s4_parked2", parked_2, 32'h3335_2223);
    chk("s4_parked3", parked_3, 32'h5559_4447);

    // scenario 5: free two SUV slots, leak floor 1, next SUV goes to floor 2
    run_fetch("s5a", 3'd1, 16'h9423);
    exp_fee = (2 * (occ1 - 1) > 255) ? 255 : 2 * (occ1 - 1);
    chk("s5_fee_suv", {24'd0, fee}, exp_fee);
    run_fetch("s5b", 3'd2, 16'h2223);
    chk("s5_empty_suv", {28'd0, empty_suv}, 32'd2);
    leakage = 1'b1; leakage_floor = 3'd0;
    step();
    chk("s5_leak_floor0", {28'd0, empty_suv}, 32'd2);
    leakage_floor = 3'd1;
    step();
    chk("s5_leak_empty", {28'd0, empty_suv}, 32'd1);
    sb.push_back('{3'd2, 1'b0, 16'h7777});
    request(1'b1, 16'h7777, 1);
    run_park("s5c");
    chk("s5_parked2", parked_2, 32'h3335_7777);
    chk("s5_leak_full", {31'd0, full_suv}, 32'd1);
    leakage = 1'b0;
    step();
    chk("s5_noleak_empty", {28'd0, empty_suv}, 32'd1);
    chk("unit_step", step_err, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    // scenario 6: reset mid-climb discards the job and the tower contents
    request(1'b1, 16'h8888, 1);
    wait_state(ST_UP, "s6");
    step();
    reset = 1'b1;
    step();
    chk("s6_state", {29'd0, curr_state_for_test}, 32'd0);
    chk("s6_floor", {29'd0, current_floor}, 32'd0);
    chk("s6_moving", {16'd0, moving}, 32'd0);
    chk("s6_fee", {24'd0, fee}, 32'd0);
    chk("s6_parked", parked_1 | parked_2 | parked_3 | parked_4 | parked_5 | parked_6 | parked_7, 32'd0);
    chk("s6_target", {28'd0, target_floor, target_place}, 32'd0);
    chk("s6_type", {31'd0, plate_type}, 32'd0);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
